// File: rtl/mux_8_to_1_pkg.sv
// Shared constants for the 8-to-1 lane selector.
package mux_8_to_1_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned SEL_W     = $clog2(NUM_LANES);

endpackage : mux_8_to_1_pkg

// File: rtl/mux_8_to_1_if.sv
// Lane-select bus: packed input lanes, select, valid in; combinational and registered results out.
interface mux_8_to_1_if #(
    parameter int unsigned W = 1
);
    import mux_8_to_1_pkg::*;

    logic [NUM_LANES*W-1:0] a;
    logic [SEL_W-1:0]       sel;
    logic                   in_valid;
    logic [W-1:0]           y_comb;
    logic [W-1:0]           y;
    logic                   out_valid;

    modport master (
        output a, sel, in_valid,
        input  y_comb, y, out_valid
    );

    modport slave (
        input  a, sel, in_valid,
        output y_comb, y, out_valid
    );

endinterface : mux_8_to_1_if

// File: rtl/mux_8_to_1_core.sv
// Combinational 8-way lane select; every select code decodes to a lane.
module mux_8_to_1_core
    import mux_8_to_1_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic [NUM_LANES*W-1:0] a,
    input  logic [SEL_W-1:0]       sel,
    output logic [W-1:0]           y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (sel == SEL_W'(i)) begin
                y = a[i*W +: W];
            end
        end
    end

endmodule : mux_8_to_1_core

// File: rtl/mux_8_to_1.sv
// Lane selector top: zero-latency result plus a valid-qualified registered copy.
module mux_8_to_1
    import mux_8_to_1_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_8_to_1_if.slave  bus
);

    logic [W-1:0] lane_sel;
    logic [W-1:0] y_q;
    logic         valid_q;

    mux_8_to_1_core #(
        .W (W)
    ) u_core (
        .a   (bus.a),
        .sel (bus.sel),
        .y   (lane_sel)
    );

    // Capture only on valid cycles; y holds otherwise while valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                y_q <= lane_sel;
            end
        end
    end

    assign bus.y_comb    = lane_sel;
    assign bus.y         = y_q;
    assign bus.out_valid = valid_q;

endmodule : mux_8_to_1

// File: tb/tb_mux_8_to_1.sv
// Self-checking bench for mux_8_to_1 at W=1 and W=8.
module tb_mux_8_to_1;

    logic clk;
    logic rst_n;

    mux_8_to_1_if #(.W(1)) if1 ();
    mux_8_to_1_if #(.W(8)) if8 ();

    mux_8_to_1 #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_8_to_1 #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] sel;
        logic       exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: lane k occupies bits [k*W +: W], so shift right by k*W and keep W bits.
    function automatic logic ref1(input logic [7:0] a, input int s);
        return 1'((a >> s) & 8'h01);
    endfunction

    function automatic logic [7:0] ref8(input logic [63:0] a, input int s);
        return 8'((a >> (s * 8)) & 64'hFF);
    endfunction

    task automatic drive1(input logic [7:0] a, input logic [2:0] s, input logic v);
        if1.a = a; if1.sel = s; if1.in_valid = v;
    endtask

    task automatic drive8(input logic [63:0] a, input logic [2:0] s, input logic v);
        if8.a = a; if8.sel = s; if8.in_valid = v;
    endtask

    vec_t vecs[8];
    logic       ey1, ev1, ev8;
    logic [7:0] ey8;

    initial begin
        vecs[0] = '{8'b00000000, 3'd0, 1'b0};
        vecs[1] = '{8'b11110000, 3'd1, 1'b0};
        vecs[2] = '{8'b10101010, 3'd2, 1'b0};
        vecs[3] = '{8'b11001100, 3'd3, 1'b1};
        vecs[4] = '{8'b11111111, 3'd4, 1'b1};
        vecs[5] = '{8'b00001111, 3'd5, 1'b0};
        vecs[6] = '{8'b01010101, 3'd6, 1'b1};
        vecs[7] = '{8'b10101010, 3'd7, 1'b1};

        // Reset held with valid input present: registered outputs stay clear.
        rst_n = 1'b0;
        drive1(8'hFF, 3'd3, 1'b1);
        drive8(64'h0123_4567_89AB_CDEF, 3'd2, 1'b1);
        #1;
        check("reset_ycomb", 64'(if1.y_comb), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_y", 64'(if1.y), 64'd0);
            check("reset_ov", 64'(if1.out_valid), 64'd0);
            check("reset_y8", 64'(if8.y), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive8(64'd0, 3'd0, 1'b0);

        // Table sweep, W=1.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive1(vecs[i].a, vecs[i].sel, 1'b1);
            #1;
            check($sformatf("tbl_ycomb[%0d]", i), 64'(if1.y_comb), 64'(vecs[i].exp));
            @(posedge clk); #1;
            check($sformatf("tbl_y[%0d]", i), 64'(if1.y), 64'(vecs[i].exp));
            check($sformatf("tbl_ov[%0d]", i), 64'(if1.out_valid), 64'd1);
        end

        // Hold: y keeps the captured value while in_valid is low.
        @(negedge clk);
        drive1(8'b10000000, 3'd7, 1'b1);
        @(posedge clk); #1;
        check("hold_cap", 64'(if1.y), 64'd1);
        @(negedge clk);
        drive1(8'h00, 3'd7, 1'b0);
        #1;
        check("hold_ycomb", 64'(if1.y_comb), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("hold_y", 64'(if1.y), 64'd1);
            check("hold_ov", 64'(if1.out_valid), 64'd0);
        end

        // Walking one across every select code.
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                drive1(8'(1 << k), 3'(s), 1'b1);
                #1;
                check($sformatf("walk_ycomb[%0d,%0d]", k, s), 64'(if1.y_comb), 64'(s == k));
                @(posedge clk); #1;
                check($sformatf("walk_y[%0d,%0d]", k, s), 64'(if1.y), 64'(s == k));
            end
        end

        // Async reset between edges clears outputs before the next edge.
        @(negedge clk);
        drive1(8'h01, 3'd0, 1'b1);
        drive8(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_y", 64'(if1.y), 64'd1);
        check("pre_rst_y8", 64'(if8.y), 64'hFF);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_y", 64'(if1.y), 64'd0);
        check("async_ov", 64'(if1.out_valid), 64'd0);
        check("async_y8", 64'(if8.y), 64'd0);
        check("async_ov8", 64'(if8.out_valid), 64'd0);
        @(posedge clk); #1;
        check("rst_held_y", 64'(if1.y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(8'b00100000, 3'd5, 1'b1);
        drive8(64'd0, 3'd0, 1'b0);
        @(posedge clk); #1;
        check("post_rst_y", 64'(if1.y), 64'd1);
        check("post_rst_ov", 64'(if1.out_valid), 64'd1);
        check("post_rst_ov8", 64'(if8.out_valid), 64'd0);

        // W=8 lane 5.
        @(negedge clk);
        drive1(8'h00, 3'd0, 1'b0);
        drive8({8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00}, 3'd5, 1'b1);
        #1;
        check("w8_ycomb", 64'(if8.y_comb), 64'h55);
        @(posedge clk); #1;
        check("w8_y", 64'(if8.y), 64'h55);
        check("w8_ov", 64'(if8.out_valid), 64'd1);

        // Randomized traffic on both widths against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  ra1;
            logic [63:0] ra8;
            logic [2:0]  rs1, rs8;
            logic        rv1, rv8;
            ra1 = 8'($urandom);
            ra8 = {32'($urandom), 32'($urandom)};
            rs1 = 3'($urandom_range(0, 7));
            rs8 = 3'($urandom_range(0, 7));
            rv1 = (i == 0) ? 1'b1 : 1'($urandom);
            rv8 = (i == 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            drive1(ra1, rs1, rv1);
            drive8(ra8, rs8, rv8);
            #1;
            check("rnd_ycomb1", 64'(if1.y_comb), 64'(ref1(ra1, int'(rs1))));
            check("rnd_ycomb8", 64'(if8.y_comb), 64'(ref8(ra8, int'(rs8))));
            if (rv1) ey1 = ref1(ra1, int'(rs1));
            if (rv8) ey8 = ref8(ra8, int'(rs8));
            ev1 = rv1;
            ev8 = rv8;
            @(posedge clk); #1;
            check("rnd_y1", 64'(if1.y), 64'(ey1));
            check("rnd_ov1", 64'(if1.out_valid), 64'(ev1));
            check("rnd_y8", 64'(if8.y), 64'(ey8));
            check("rnd_ov8", 64'(if8.out_valid), 64'(ev8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_8_to_1

// File: doc/mux_8_to_1.md
Name: mux_8_to_1

Overview:
- 8-input, 1-output selector: output lane = input lane indexed by a 3-bit select.
- Provides a zero-latency combinational result and a registered, valid-qualified result for timing closure downstream.
- Used as a generic lane-select primitive inside datapath blocks.
- Single clock domain.

Parameters:
- W, 1, width in bits of each of the 8 input lanes and of the outputs.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
- a  input  8*W  packed input lanes; lane i = a[i*W +: W], lane 0 in the LSBs.
- sel  input  3  lane index 0..7.
- in_valid  input  1  qualifies a/sel for capture into the output register.
- y_comb  output  W  combinational selected lane, a[sel*W +: W].
- y  output  W  registered selected lane.
- out_valid  output  1  y holds a result captured on the previous in_valid cycle.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- y_comb:
  - Purely combinational, equals lane sel of a at all times, including during reset.
  - No latches; all 8 sel codes are decoded.
  - No X propagation for defined inputs.
- Reset (rst_n=0, asynchronous, immediate): y = 0, out_valid = 0.
- After reset, each rising edge of clk:
  - in_valid=1: y <= lane sel of a; out_valid <= 1.
  - in_valid=0: y holds its previous value; out_valid <= 0.
- Latency and throughput:
  - y_comb latency is 0.
  - y latency is 1 cycle from the in_valid sample.
  - Throughput is one selection per cycle.
  - No backpressure; no handshake beyond in_valid/out_valid.
- Boundary conditions:
  - sel=0 selects a[W-1:0].
  - sel=7 selects a[8W-1:7W].
  - Changing sel and a in the same cycle: the captured value uses both new values sampled at that edge.
  - Reset asserted mid-stream: y and out_valid clear immediately. The first capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.
- Arithmetic: none; pure selection. Output width is exactly W bits, no extension.

Decomposition:
- Shared package holds the constants:
  - NUM_LANES = 8.
  - SEL_W = 3 (equal to $clog2(NUM_LANES)).
- One natural sub-module, mux_8_to_1_core:
  - Combinational lane select, parameterised by W.
  - Drives y_comb.
- The top level adds the capture register and the valid flop.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=8'hFF, sel=3 -> y=0 and out_valid=0 throughout. y_comb=1.
- W=1 sweep, one vector per cycle with in_valid=1:
  - (a=8'b00000000, sel=0) -> y_comb=0
  - (8'b11110000, 1) -> 0
  - (8'b10101010, 2) -> 0
  - (8'b11001100, 3) -> 1
  - (8'b11111111, 4) -> 1
  - (8'b00001111, 5) -> 0
  - (8'b01010101, 6) -> 1
  - (8'b10101010, 7) -> 1
  - For every vector, y equals the same value one cycle later and out_valid=1.
- Hold: capture a=8'b10000000, sel=7 (y=1), then drive in_valid=0 with a=0 -> y stays 1, out_valid=0, y_comb=0.
- Walking one: a = 1<<k for k=0..7, sweep all 8 sel -> y_comb=1 only when sel==k, else 0; y follows one cycle later.
- Async reset mid-stream: assert rst_n=0 between clock edges while y=1 -> y=0 and out_valid=0 before the next edge. After release, the first in_valid capture behaves normally.
- W=8: a = {8'h77,8'h66,8'h55,8'h44,8'h33,8'h22,8'h11,8'h00}, sel=5 -> y_comb=8'h55; y=8'h55 one cycle later.
